array_read_arbiter: RTL and testbench



---
 rtl/array_read_arbiter.sv | 104 ++++++++++
 tb/tb_array_read_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/array_read_arbiter.sv
// Round-robin arbiter sharing one array read port among N requesters.
// One read outstanding at a time; each response is returned to the requester that issued it.
module array_read_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [N-1:0]    req_valid,
   output logic [N-1:0]    req_ready,
   input  logic [N*AW-1:0] req_addr,
   output logic [N-1:0]    resp_valid,
   input  logic [N-1:0]    resp_ready,
   output logic [DW-1:0]   resp_data,
   output logic [AW-1:0]   arr_addr,
   output logic            arr_addr_valid,
   input  logic            arr_addr_ready,
   input  logic [DW-1:0]   arr_data,
   input  logic            arr_data_valid
);

   localparam int unsigned GW = $clog2(N);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [GW-1:0]   r_last;
   logic [GW-1:0]   r_gnt;
   logic [GW-1:0]   w_sel;
   logic            w_found;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_data;

   // Scan from r_last+1 upward with wrap; N need not be a power of two.
   always_comb begin : arb
      int unsigned idx;
      w_found = 1'b0;
      w_sel   = '0;
      idx     = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = i + 32'(r_last);
         if (idx >= N) idx = idx - N;
         if (!w_found && req_valid[idx[GW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = idx[GW-1:0];
         end
      end
   end

   always_comb begin
      w_next         = r_state;
      req_ready      = '0;
      resp_valid     = '0;
      resp_data      = '0;
      arr_addr       = '0;
      arr_addr_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               req_ready[w_sel] = 1'b1;
               w_next           = ISSUE;
            end
         end
         ISSUE: begin
            arr_addr_valid = 1'b1;
            arr_addr       = r_addr;
            if (arr_addr_ready) w_next = WAIT;
         end
         WAIT: begin
            if (arr_data_valid) w_next = RESP;
         end
         RESP: begin
            resp_valid[r_gnt] = 1'b1;
            resp_data         = r_data;
            if (resp_ready[r_gnt]) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_last <= GW'(N - 1);
         r_gnt  <= '0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         if (r_state == IDLE && w_found) begin
            r_addr <= req_addr[w_sel*AW +: AW];
            r_gnt  <= w_sel;
            r_last <= w_sel;
         end
         if (r_state == WAIT && arr_data_valid) r_data <= arr_data;
      end
   end

endmodule

// File: tb/tb_array_read_arbiter.sv
// Directed bench for array_read_arbiter (N=3) with a small array model, mem[k]=k+10.
module tb_array_read_arbiter;

   logic        clk = 1'b0;
   logic        nrst;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [23:0] req_addr;
   logic [2:0]  resp_valid;
   logic [2:0]  resp_ready;
   logic [7:0]  resp_data;
   logic [7:0]  arr_addr;
   logic        arr_addr_valid;
   logic        arr_addr_ready;
   logic [7:0]  arr_data;
   logic        arr_data_valid;

   int checks   = 0;
   int failures = 0;

   logic        pend  = 1'b0;
   int unsigned cnt   = 0;
   int unsigned lat   = 1;
   logic [7:0]  pdata = '0;

   array_read_arbiter #(.N(3), .AW(8), .DW(8)) dut (
      .clk            (clk),
      .nrst           (nrst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_data      (resp_data),
      .arr_addr       (arr_addr),
      .arr_addr_valid (arr_addr_valid),
      .arr_addr_ready (arr_addr_ready),
      .arr_data       (arr_data),
      .arr_data_valid (arr_data_valid)
   );

   always #5 clk = ~clk;

   // Array model: data appears lat cycles after the address handshake.
   always @(posedge clk) begin
      if (pend) begin
         if (cnt == 1) pend <= 1'b0;
         else          cnt  <= cnt - 1;
      end
      if (arr_addr_valid && arr_addr_ready) begin
         pend  <= 1'b1;
         cnt   <= lat;
         pdata <= arr_addr + 8'd10;
      end
   end
   assign arr_data_valid = pend && (cnt == 1);
   assign arr_data       = pdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_arr_valid"}, arr_addr_valid, 0);
      chk({tag, "_arr_addr"}, arr_addr, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_data"}, resp_data, 0);
   endtask

   // One full transaction with ready array (latency 1) and resp_ready asserted.
   task automatic serve(input logic [2:0] rv, input logic [2:0] g, input logic [7:0] a, input logic [7:0] d);
      req_valid = rv;
      #1;
      chk("grant", req_ready, g);
      tick();
      chk("issue_valid", arr_addr_valid, 1);
      chk("issue_addr", arr_addr, a);
      chk("busy_no_ready", req_ready, 0);
      tick();
      chk("wait_no_resp", resp_valid, 0);
      tick();
      chk("resp_valid", resp_valid, g);
      chk("resp_data", resp_data, d);
      tick();
      chk("retired", resp_valid, 0);
   endtask

   initial begin
      nrst           = 1'b0;
      req_valid      = '0;
      req_addr       = {8'd3, 8'd2, 8'd1};
      resp_ready     = '0;
      arr_addr_ready = 1'b1;
      repeat (2) tick();
      chk_idle_outputs("reset");
      chk("reset_req_ready", req_ready, 0);
      nrst = 1'b1;
      tick();
      chk("idle_no_req", req_ready, 0);

      // Single requester, latency 3 from accept to resp_valid
      resp_ready = 3'b001;
      serve(3'b001, 3'b001, 8'd1, 8'd11);
      req_valid  = '0;
      resp_ready = 3'b111;

      // Round-robin wrap: last=0 -> 1; then {0,2} -> 2; then {0,1} -> 0
      serve(3'b010, 3'b010, 8'd2, 8'd12);
      serve(3'b101, 3'b100, 8'd3, 8'd13);
      serve(3'b011, 3'b001, 8'd1, 8'd11);
      req_valid = '0;
      tick();

      // Address and response backpressure (last=0, so requester 1 wins)
      arr_addr_ready = 1'b0;
      resp_ready     = 3'b101;
      req_valid      = 3'b010;
      #1;
      chk("bp_grant", req_ready, 3'b010);
      tick();
      req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_addr_valid", arr_addr_valid, 1);
         chk("bp_addr", arr_addr, 8'd2);
         tick();
      end
      arr_addr_ready = 1'b1;
      chk("bp_addr_valid_end", arr_addr_valid, 1);
      tick();
      tick();
      req_valid = 3'b111;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_resp_valid", resp_valid, 3'b010);
         chk("stall_resp_data", resp_data, 8'd12);
         chk("stall_no_ready", req_ready, 0);
         tick();
      end
      resp_ready = 3'b111;
      tick();
      req_valid = '0;
      #1;
      chk("dropped_req_ready", req_ready, 0);
      tick();
      chk("dropped_not_served", arr_addr_valid, 0);

      // Array latency 6; stray resp_ready from non-granted requesters
      lat        = 6;
      resp_ready = 3'b011;
      req_valid  = 3'b100;
      #1;
      chk("lat_grant", req_ready, 3'b100);
      tick();
      req_valid = '0;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("lat_wait_resp", resp_valid, 0);
         chk("lat_wait_addr", arr_addr_valid, 0);
         tick();
      end
      chk("lat_resp_valid", resp_valid, 3'b100);
      chk("lat_resp_data", resp_data, 8'd13);
      tick();
      chk("stray_ignored", resp_valid, 3'b100);
      resp_ready = 3'b100;
      tick();
      chk("lat_retired", resp_valid, 0);
      resp_ready = 3'b111;

      // Reset in WAIT (last=2 -> requester 0 wins); late data must be ignored
      lat       = 4;
      req_valid = 3'b001;
      #1;
      chk("rst_pre_grant", req_ready, 3'b001);
      tick();
      req_valid = '0;
      tick();
      tick();
      #3;
      nrst = 1'b0;
      #1;
      chk_idle_outputs("async_rst");
      #2;
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle_outputs("late_data");
      end
      lat = 1;

      // Three simultaneous after reset: order 0,1,2, each accept 4 cycles apart
      serve(3'b111, 3'b001, 8'd1, 8'd11);
      serve(3'b111, 3'b010, 8'd2, 8'd12);
      serve(3'b111, 3'b100, 8'd3, 8'd13);
      req_valid = '0;
      tick();
      chk_idle_outputs("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
